// File: rtl/muldiv_if.sv
// Operand/result bundle between execute-stage control and the multiply/divide unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, data1, data2, mthi, mtlo,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, data1, data2, mthi, mtlo,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS HI/LO unit: shift-add multiply and restoring divide, one bit per clock,
// with sign handling done on magnitudes and corrected in a final FIX cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;
  typedef enum logic [1:0] {OP_MULTU, OP_MULT, OP_DIVU, OP_DIV} op_e;

  state_e           state, state_n;
  op_e              op_q;
  logic [CW-1:0]    cnt;
  logic             sign1, sign2;
  logic [WIDTH-1:0] raw1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q, dbz_q;

  logic             is_signed_in;
  logic [WIDTH-1:0] mag1_in, mag2_in;
  logic [WIDTH:0]   add_sum, shifted, diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = RUN;
      RUN:     if (cnt == CW'(WIDTH - 1)) state_n = FIX;
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand magnitudes at the accept edge; the most negative value maps to itself as unsigned.
  always_comb begin
    is_signed_in = bus.op[0];
    mag1_in = (is_signed_in && bus.data1[WIDTH-1]) ? -bus.data1 : bus.data1;
    mag2_in = (is_signed_in && bus.data2[WIDTH-1]) ? -bus.data2 : bus.data2;
  end

  // acc/q double as product upper/lower halves for multiply and remainder/quotient for divide.
  always_comb begin
    add_sum = {1'b0, acc} + (q[0] ? {1'b0, mag2} : '0);
    shifted = {acc, q[WIDTH-1]};
    diff    = shifted - {1'b0, mag2};
  end

  always_comb begin
    prod     = {acc, q};
    prod_fix = (op_q == OP_MULT && (sign1 ^ sign2)) ? -prod : prod;
    quot_fix = (op_q == OP_DIV && (sign1 ^ sign2)) ? -q : q;
    rem_fix  = (op_q == OP_DIV && sign1) ? -acc : acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= OP_MULTU;
      cnt    <= '0;
      sign1  <= 1'b0;
      sign2  <= 1'b0;
      raw1   <= '0;
      mag2   <= '0;
      acc    <= '0;
      q      <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mthi) hi_q <= bus.data1;
          if (bus.mtlo) lo_q <= bus.data1;
          if (bus.start) begin
            op_q  <= op_e'(bus.op);
            sign1 <= bus.op[0] & bus.data1[WIDTH-1];
            sign2 <= bus.op[0] & bus.data2[WIDTH-1];
            raw1  <= bus.data1;
            mag2  <= mag2_in;
            q     <= mag1_in;
            acc   <= '0;
            cnt   <= '0;
            dbz_q <= 1'b0;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (op_q[1]) begin
            if (!diff[WIDTH]) begin
              acc <= diff[WIDTH-1:0];
              q   <= {q[WIDTH-2:0], 1'b1};
            end else begin
              acc <= shifted[WIDTH-1:0];
              q   <= {q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc <= add_sum[WIDTH:1];
            q   <= {add_sum[0], q[WIDTH-1:1]};
          end
        end
        FIX: begin
          done_q <= 1'b1;
          if (op_q[1]) begin
            if (mag2 == '0) begin
              hi_q  <= raw1;
              lo_q  <= '1;
              dbz_q <= 1'b1;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO computed with plain 64-bit arithmetic.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32)) bus();
  muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int unsigned start_cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          done_seen = 0;
  int          done_exp = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sb, qv, rv;
    e.dbz = 1'b0;
    e.start_cyc = 0;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'd0: p = {32'h0, a} * {32'h0, b};
      2'd1: p = sa * sb;
      default: p = '0;
    endcase
    if (op[1] && b == 32'h0) begin
      e.hi = a;
      e.lo = 32'hFFFF_FFFF;
      e.dbz = 1'b1;
    end else if (op == 2'd2) begin
      e.lo = a / b;
      e.hi = a % b;
    end else if (op == 2'd3) begin
      qv = sa / sb;
      rv = sa % sb;
      e.lo = qv[31:0];
      e.hi = rv[31:0];
    end else begin
      e.hi = p[63:32];
      e.lo = p[31:0];
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding operation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      done_seen++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        mon_e = sbq.pop_front();
        check("hi", bus.hi, mon_e.hi);
        check("lo", bus.lo, mon_e.lo);
        check("div_by_zero", {31'b0, bus.div_by_zero}, {31'b0, mon_e.dbz});
        check("latency", cyc - mon_e.start_cyc, 32'd33);
      end
    end
  end

  // Called just after a negedge; leaves start deasserted one negedge later.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bus.start = 1'b1;
    bus.op    = op;
    bus.data1 = a;
    bus.data2 = b;
    if (bus.busy === 1'b0) begin
      e = model(op, a, b);
      e.start_cyc = cyc + 1;
      sbq.push_back(e);
      done_exp++;
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got busy=%b expected 0 within 100 cycles", bus.busy);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int n;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.op = 2'd0;
    bus.data1 = '0;
    bus.data2 = '0;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_dbz", {31'b0, bus.div_by_zero}, 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // MULTU max operands with busy-length measurement
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", n, 32'd33);
    @(negedge clk);

    issue(2'd1, 32'hFFFF_FFFD, 32'd7);
    wait_idle();
    @(negedge clk);
    issue(2'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    @(negedge clk);

    issue(2'd2, 32'd100, 32'd0);
    wait_idle();
    @(negedge clk);
    issue(2'd2, 32'd100, 32'd7);
    wait_idle();
    @(negedge clk);

    // start and mthi while busy must be ignored
    issue(2'd2, 32'd50, 32'd5);
    repeat (4) @(negedge clk);
    issue(2'd0, 32'd9, 32'd9);
    repeat (2) @(negedge clk);
    bus.mthi = 1'b1;
    bus.data1 = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.mthi = 1'b0;
    wait_idle();
    @(negedge clk);

    // reset mid-run aborts
    issue(2'd0, 32'd123, 32'd456);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    done_exp -= sbq.size();
    sbq.delete();
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_done", {31'b0, bus.done}, 32'd0);
    check("abort_hi", bus.hi, 32'd0);
    check("abort_lo", bus.lo, 32'd0);
    repeat (40) @(negedge clk);
    issue(2'd0, 32'd6, 32'd7);
    wait_idle();
    @(negedge clk);

    // back-to-back: start in the done cycle
    issue(2'd0, 32'd3, 32'd4);
    wait_idle();
    issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    @(negedge clk);

    // direct HI/LO writes in IDLE
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    bus.data1 = 32'h1234_5678;
    @(negedge clk);
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    check("mthi", bus.hi, 32'h1234_5678);
    check("mtlo", bus.lo, 32'h1234_5678);
    bus.mtlo = 1'b1;
    bus.data1 = 32'hCAFE_0000;
    @(negedge clk);
    bus.mtlo = 1'b0;
    check("mtlo_only_lo", bus.lo, 32'hCAFE_0000);
    check("mtlo_only_hi", bus.hi, 32'h1234_5678);

    // randomized operations, with operand scrambling and ignored writes while busy
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
      bus.mthi = ($urandom_range(0, 3) == 0);
      bus.mtlo = ($urandom_range(0, 3) == 0);
      issue(rop, ra, rb);
      bus.mthi = 1'b0;
      bus.mtlo = 1'b0;
      repeat ($urandom_range(1, 20)) @(negedge clk);
      bus.data1 = $urandom;
      bus.data2 = $urandom;
      bus.mthi = 1'b1;
      bus.mtlo = 1'b1;
      @(negedge clk);
      bus.mthi = 1'b0;
      bus.mtlo = 1'b0;
      wait_idle();
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("done_count", done_seen, done_exp);
    check("pending_left", sbq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
